btb_update_ctrl: RTL
====================

BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 lu_req  in  1  fetch lookup request; lu_pc in 32 lookup PC; lu_ready out 1 lookup granted this cycle.
REQ-004 lu_rvalid  out  1  set data valid; lu_set_data out 128 set read for the previous granted lookup; lu_tag out 27 registered lu_pc[31:5].
REQ-005 upd_valid  in  1  resolved-branch update; upd_pc in 32; upd_target in 32; upd_taken in 1; upd_ready out 1 update accepted this cycle.
REQ-006 flush_req  in  1  invalidate all sets; flush_done out 1 one-cycle pulse when the flush completes.
REQ-007 mem_en out 1, mem_we out 1, mem_idx out 3, mem_wdata out 128, mem_rdata in 128: single-port set memory with 1-cycle read latency.
REQ-008 busy  out  1  high in any state other than IDLE.

Function
REQ-009 Address split SHALL be index = pc[4:2] (8 sets) and tag = pc[31:5].
REQ-010 Set layout SHALL be: way1 valid[127] tag[126:100] target[99:68] fsm[67:66]; way2 valid[63] tag[62:36] target[35:4] fsm[3:2]; lru[0] (0 = way1 is victim, 1 = way2 is victim); all other bits written as 0.
REQ-011 FSM states SHALL be IDLE, UPD_WR and FLUSH.
REQ-012 IDLE priority SHALL be: flush_req first; then upd_valid if lu_req=0 or starve_cnt=3; otherwise lu_req.
REQ-013 starve_cnt (2 bits) SHALL increment, saturating at 3, in each cycle where upd_valid=1 and the update is not granted; it SHALL clear on update grant.
REQ-014 Lookup grant SHALL drive lu_ready=1, mem_en=1, mem_we=0 and mem_idx=lu_pc index in the same cycle; in the next cycle lu_rvalid=1, lu_set_data=mem_rdata and lu_tag=the captured tag.
REQ-015 Update grant SHALL drive upd_ready=1 and a read of the upd_pc index in the same cycle, register pc, target and taken, then enter UPD_WR.
REQ-016 UPD_WR SHALL compute new set data from mem_rdata and drive the write (mem_en=1, mem_we=1) in that cycle only when a write is required; the next state SHALL be IDLE; lu_ready=0 and upd_ready=0.
REQ-017 Hit in way w (valid and tag equal; way1 wins if both hit): fsm SHALL be incremented if taken (saturate at 3) or decremented if not taken (saturate at 0); target SHALL be replaced only if taken; lru SHALL point to the other way.
REQ-018 Miss with taken=1 SHALL allocate the first invalid way (way1 before way2), otherwise the way selected by lru; it SHALL write valid=1, tag, target and fsm=2'b10, then set lru to the other way.
REQ-019 Miss with taken=0 SHALL write nothing: mem_en=0 in UPD_WR.
REQ-020 FLUSH SHALL write 128'b0 to idx 0..7, one set per cycle, using a 3-bit counter; after idx 7 it SHALL pulse flush_done and return to IDLE; lookups and updates SHALL not be granted during FLUSH.
REQ-021 Lookups SHALL never modify lru or fsm.
REQ-022 A lookup granted the cycle after an update write to the same index SHALL return the updated data.

Reset
REQ-023 With rst high, the FSM SHALL enter IDLE and starve_cnt and the flush counter SHALL clear; lu_ready, lu_rvalid, upd_ready, flush_done, busy, mem_en and mem_we SHALL be 0; lu_set_data and lu_tag SHALL be 0.
REQ-024 Reset during UPD_WR or FLUSH SHALL abort the operation with no further memory write; memory contents SHALL NOT be cleared by reset.

Structure
REQ-025 The btb_pkg package SHALL hold the field bit positions, INDEX_W=3, TAG_W=27, the FSM state enum and the counter constants (WEAK_TAKEN=2'b10).
REQ-026 The set-modify logic of REQ-017 to REQ-019 SHALL be one combinational sub-module, btb_set_update.

Verification
REQ-027 Empty set, update pc=0x0000_1008, taken, target=0x2000 -> UPD_WR writes idx 2, bits[127:64]={1, tag 0x80, 0x2000, 2'b10, 2'b00}, lru=1.
REQ-028 Repeat the same update 3x taken, then 4x not-taken -> way1 fsm goes 3,3,3 then 2,1,0,0; target unchanged on not-taken.
REQ-029 Both ways valid, lru=0, new-tag taken update -> way1 replaced, lru=1; next new-tag taken update -> way2 replaced, lru=0.
REQ-030 lu_req held high with upd_valid high -> update granted on its 4th cycle of waiting; lookup stalls for 2 cycles.
REQ-031 flush_req -> 8 consecutive writes of 0 to idx 0..7, flush_done pulses once, busy=1 for 8 cycles; a following lookup returns all-zero set data.
REQ-032 rst asserted in UPD_WR -> no write issued; the next cycle shows all outputs 0 and the FSM in IDLE.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared BTB constants, set layout and counter helper.
package btb_pkg;

  localparam int unsigned PC_W       = 32;
  localparam int unsigned INDEX_W    = 3;
  localparam int unsigned TAG_W      = 27;
  localparam int unsigned SET_W      = 128;
  localparam int unsigned FSM_W      = 2;
  localparam int unsigned STARVE_W   = 2;
  localparam int unsigned OFFSET_LSB = 2;
  localparam int unsigned TAG_LSB    = 5;

  // Field bit positions inside a 128-bit set
  localparam int unsigned W1_VALID_BIT = 127;
  localparam int unsigned W1_TAG_LSB   = 100;
  localparam int unsigned W1_TGT_LSB   = 68;
  localparam int unsigned W1_FSM_LSB   = 66;
  localparam int unsigned W2_VALID_BIT = 63;
  localparam int unsigned W2_TAG_LSB   = 36;
  localparam int unsigned W2_TGT_LSB   = 4;
  localparam int unsigned W2_FSM_LSB   = 2;
  localparam int unsigned LRU_BIT      = 0;

  localparam logic [FSM_W-1:0]    WEAK_TAKEN = 2'b10;
  localparam logic [FSM_W-1:0]    FSM_MAX    = 2'b11;
  localparam logic [FSM_W-1:0]    FSM_MIN    = 2'b00;
  localparam logic [STARVE_W-1:0] STARVE_MAX = 2'b11;
  localparam logic [INDEX_W-1:0]  INDEX_MAX  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPD_WR = 2'd1,
    ST_FLUSH  = 2'd2
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [PC_W-1:0]   target;
    logic [FSM_W-1:0]  fsm;
  } way_t;

  // Reserved gaps are sized from the field positions above
  typedef struct packed {
    way_t                                  w1;
    logic [W1_FSM_LSB-W2_VALID_BIT-2:0]    rsv1;
    way_t                                  w2;
    logic [W2_FSM_LSB-LRU_BIT-2:0]         rsv0;
    logic                                  lru;
  } set_t;

  // Saturating 2-bit counter training; target follows taken outcomes only
  function automatic way_t train_way(input way_t w, input logic [PC_W-1:0] tgt, input logic taken);
    way_t r;
    r = w;
    if (taken) begin
      r.target = tgt;
      if (w.fsm != FSM_MAX) r.fsm = w.fsm + FSM_W'(1);
    end else if (w.fsm != FSM_MIN) begin
      r.fsm = w.fsm - FSM_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/btb_set_update.sv
// Combinational read-modify of one BTB set for a resolved branch.
module btb_set_update
  import btb_pkg::*;
(
  input  logic [SET_W-1:0] old_set,
  input  logic [TAG_W-1:0] upd_tag,
  input  logic [PC_W-1:0]  upd_target,
  input  logic             upd_taken,
  output logic [SET_W-1:0] new_set_c,
  output logic             write_c
);

  set_t cur;
  set_t nxt;
  way_t fresh;
  logic hit1;
  logic hit2;
  logic alloc_w2;

  assign cur      = set_t'(old_set);
  assign hit1     = cur.w1.valid && (cur.w1.tag == upd_tag);
  assign hit2     = !hit1 && cur.w2.valid && (cur.w2.tag == upd_tag);
  // First invalid way wins; with both valid the lru bit names the victim
  assign alloc_w2 = cur.w1.valid && (!cur.w2.valid || cur.lru);
  assign fresh    = '{valid: 1'b1, tag: upd_tag, target: upd_target, fsm: WEAK_TAKEN};

  // Hit trains the way, taken miss allocates, untaken miss leaves the set alone
  always_comb begin
    nxt      = cur;
    nxt.rsv1 = '0;
    nxt.rsv0 = '0;
    write_c  = 1'b0;
    if (hit1) begin
      nxt.w1  = train_way(cur.w1, upd_target, upd_taken);
      nxt.lru = 1'b1;
      write_c = 1'b1;
    end else if (hit2) begin
      nxt.w2  = train_way(cur.w2, upd_target, upd_taken);
      nxt.lru = 1'b0;
      write_c = 1'b1;
    end else if (upd_taken) begin
      if (alloc_w2) begin
        nxt.w2  = fresh;
        nxt.lru = 1'b0;
      end else begin
        nxt.w1  = fresh;
        nxt.lru = 1'b1;
      end
      write_c = 1'b1;
    end
  end

  assign new_set_c = nxt;

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB set-memory arbiter: fetch lookups, branch updates and full flush.
module btb_update_ctrl
  import btb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               lu_req,
  input  logic [PC_W-1:0]    lu_pc,
  output logic               lu_ready,
  output logic               lu_rvalid,
  output logic [SET_W-1:0]   lu_set_data,
  output logic [TAG_W-1:0]   lu_tag,
  input  logic               upd_valid,
  input  logic [PC_W-1:0]    upd_pc,
  input  logic [PC_W-1:0]    upd_target,
  input  logic               upd_taken,
  output logic               upd_ready,
  input  logic               flush_req,
  output logic               flush_done,
  output logic               mem_en,
  output logic               mem_we,
  output logic [INDEX_W-1:0] mem_idx,
  output logic [SET_W-1:0]   mem_wdata,
  input  logic [SET_W-1:0]   mem_rdata,
  output logic               busy
);

  state_e              state;
  logic [STARVE_W-1:0] starve_cnt;
  logic [INDEX_W-1:0]  flush_cnt;
  logic [INDEX_W-1:0]  upd_idx_q;
  logic [TAG_W-1:0]    upd_tag_q;
  logic [PC_W-1:0]     upd_target_q;
  logic                upd_taken_q;
  logic                lu_grant;
  logic                upd_grant;
  logic [SET_W-1:0]    new_set;
  logic                set_write;
  logic                unused_pc_bits;

  assign unused_pc_bits = ^{lu_pc[OFFSET_LSB-1:0], upd_pc[OFFSET_LSB-1:0]};

  btb_set_update u_set_update (
    .old_set    (mem_rdata),
    .upd_tag    (upd_tag_q),
    .upd_target (upd_target_q),
    .upd_taken  (upd_taken_q),
    .new_set_c  (new_set),
    .write_c    (set_write)
  );

  // Same-cycle arbitration and memory port drive; reset blocks every access
  always_comb begin
    lu_grant  = 1'b0;
    upd_grant = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_idx   = '0;
    mem_wdata = '0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          if (!flush_req) begin
            if (upd_valid && (!lu_req || (starve_cnt == STARVE_MAX))) begin
              upd_grant = 1'b1;
              mem_en    = 1'b1;
              mem_idx   = upd_pc[TAG_LSB-1:OFFSET_LSB];
            end else if (lu_req) begin
              lu_grant = 1'b1;
              mem_en   = 1'b1;
              mem_idx  = lu_pc[TAG_LSB-1:OFFSET_LSB];
            end
          end
        end
        ST_UPD_WR: begin
          mem_en    = set_write;
          mem_we    = set_write;
          mem_idx   = upd_idx_q;
          mem_wdata = new_set;
        end
        ST_FLUSH: begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_idx   = flush_cnt;
          mem_wdata = '0;
        end
        default: ;
      endcase
    end
  end

  assign lu_ready    = lu_grant;
  assign upd_ready   = upd_grant;
  assign busy        = (state != ST_IDLE);
  assign lu_set_data = lu_rvalid ? mem_rdata : '0;

  // State, starvation counter, flush walk and captured request fields
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      starve_cnt   <= '0;
      flush_cnt    <= '0;
      lu_rvalid    <= 1'b0;
      lu_tag       <= '0;
      flush_done   <= 1'b0;
      upd_idx_q    <= '0;
      upd_tag_q    <= '0;
      upd_target_q <= '0;
      upd_taken_q  <= 1'b0;
    end else begin
      lu_rvalid  <= lu_grant;
      flush_done <= 1'b0;
      if (lu_grant) lu_tag <= lu_pc[PC_W-1:TAG_LSB];

      if (upd_grant) begin
        starve_cnt <= '0;
      end else if (upd_valid && (starve_cnt != STARVE_MAX)) begin
        starve_cnt <= starve_cnt + STARVE_W'(1);
      end

      case (state)
        ST_IDLE: begin
          if (flush_req) begin
            state     <= ST_FLUSH;
            flush_cnt <= '0;
          end else if (upd_grant) begin
            state        <= ST_UPD_WR;
            upd_idx_q    <= upd_pc[TAG_LSB-1:OFFSET_LSB];
            upd_tag_q    <= upd_pc[PC_W-1:TAG_LSB];
            upd_target_q <= upd_target;
            upd_taken_q  <= upd_taken;
          end
        end
        ST_UPD_WR: state <= ST_IDLE;
        ST_FLUSH: begin
          flush_cnt <= flush_cnt + INDEX_W'(1);
          if (flush_cnt == INDEX_MAX) begin
            state      <= ST_IDLE;
            flush_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
